// File: rtl/mod_am_multi.sv
// Multi-channel AM modulator: one strobe captures a carrier sample plus NCH channel
// samples, scales each channel by the gain, mixes it with the carrier and publishes all results together.
module mod_am_multi #(
  parameter int W   = 12,
  parameter int NCH = 4,
  parameter int GW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pls,
  input  logic             mode,
  input  logic [GW-1:0]    gain,
  input  logic [W-1:0]     carrier,
  input  logic [NCH*W-1:0] mod_in,
  output logic [NCH*W-1:0] mod_out,
  output logic             done,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(NCH + 2);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic signed [W+GW:0] S_MAX = {{(GW+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W+GW:0] S_MIN = {{(GW+2){1'b1}}, {(W-1){1'b0}}};

  logic                pl0_q, pl1_q;
  logic [0:0]          state_q;
  logic [CW-1:0]       cnt_q;
  logic                mode_q;
  logic [GW-1:0]       gain_q;
  logic signed [W-1:0] car_q;
  logic signed [W-1:0] sh_q [NCH];
  logic signed [W-1:0] res_q [NCH];
  logic signed [W-1:0] env_q;
  logic [NCH*W-1:0]    out_q;
  logic                done_q, busy_q, ovr_q;

  logic                  strobe;
  logic signed [W-1:0]   x;
  logic signed [W+GW:0]  p1, p1_sh;
  logic signed [W-1:0]   s_sat, env_d, res_d;
  logic signed [2*W-1:0] p2;
  logic                  unused_p2;

  assign strobe = pl0_q & ~pl1_q;

  // Stage 1: pick the channel addressed by the sequencing counter, scale by gain.
  always_comb begin
    x = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) x = sh_q[i];
    end
    p1    = $signed(x) * $signed({1'b0, gain_q});
    p1_sh = p1 >>> (GW - 1);
    if (p1_sh > S_MAX)      s_sat = S_MAX[W-1:0];
    else if (p1_sh < S_MIN) s_sat = S_MIN[W-1:0];
    else                    s_sat = p1_sh[W-1:0];
    // Large-carrier mode offsets the halved envelope so it never goes negative.
    env_d = mode_q ? ((s_sat >>> 1) + W'(1 << (W - 2))) : s_sat;
  end

  // Stage 2: mix with the carrier, keep Q(W-1) result, clamp on overflow.
  always_comb begin
    p2 = car_q * env_q;
    if (p2[2*W-1] == p2[2*W-2]) res_d = p2[2*W-2:W-1];
    else if (p2[2*W-1])         res_d = {1'b1, {(W-1){1'b0}}};
    else                        res_d = {1'b0, {(W-1){1'b1}}};
  end

  assign unused_p2 = ^p2[W-2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pl0_q   <= 1'b0;
      pl1_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      gain_q  <= '0;
      car_q   <= '0;
      env_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sh_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      pl0_q  <= pls;
      pl1_q  <= pl0_q;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (strobe) begin
            mode_q  <= mode;
            gain_q  <= gain;
            car_q   <= carrier;
            for (int i = 0; i < NCH; i++) sh_q[i] <= mod_in[i*W +: W];
            busy_q  <= 1'b1;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (strobe) ovr_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q < CW'(NCH)) env_q <= env_d;
          // Stage 2 lags stage 1 by one edge, so slot i is written at count i+1.
          for (int i = 0; i < NCH; i++) begin
            if (cnt_q == CW'(i + 1)) res_q[i] <= res_d;
          end
          if (cnt_q == CW'(NCH + 1)) begin
            for (int i = 0; i < NCH; i++) out_q[i*W +: W] <= res_q[i];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mod_out = out_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_mod_am_multi.sv
// Directed bench for mod_am_multi at W=12, NCH=4, GW=8 with hand-computed expected outputs.
module tb_mod_am_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pls = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  gain = '0;
  logic [11:0] carrier = '0;
  logic [47:0] mod_in = '0;
  logic [47:0] mod_out;
  logic        done, busy, overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] prev_out = '0;

  mod_am_multi #(.W(12), .NCH(4), .GW(8)) dut (
    .clk(clk), .rst(rst), .pls(pls), .mode(mode), .gain(gain),
    .carrier(carrier), .mod_in(mod_in), .mod_out(mod_out),
    .done(done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
    logic [11:0] la, lb, lc, ld;
    la = a[11:0]; lb = b[11:0]; lc = c[11:0]; ld = d[11:0];
    return {ld, lc, lb, la};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion; k counts posedges after pls rises (capture at k=1, done at k=7).
  task automatic conv(input string tag, input logic md, input logic [7:0] g,
                      input logic [11:0] car, input logic [47:0] din,
                      input logic [47:0] exp, input bit glitch);
    @(negedge clk);
    mode = md; gain = g; carrier = car; mod_in = din; pls = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check({tag, " done"}, {47'd0, done}, {47'd0, (k == 7)});
      check({tag, " out"}, mod_out, (k < 7) ? prev_out : exp);
      if (k >= 1 && k <= 6) check({tag, " busy"}, {47'd0, busy}, 48'd1);
      if (k == 7) check({tag, " idle"}, {47'd0, busy}, 48'd0);
      if (k == 1) begin
        check({tag, " ovr_clr"}, {47'd0, overrun}, 48'd0);
        mode = ~md; gain = ~g; carrier = ~car; mod_in = ~din; pls = 1'b0;
      end
      if (glitch && k == 2) pls = 1'b1;
      if (glitch && k == 3) pls = 1'b0;
      if (glitch && (k == 6 || k == 9)) check({tag, " ovr_set"}, {47'd0, overrun}, 48'd1);
    end
    prev_out = exp;
    $display("[TB] %s mode=%0d gain=%0d carrier=%0d out=%h", tag, md, g, $signed(car), mod_out);
  endtask

  initial begin
    int seen_done;
    repeat (3) @(negedge clk);
    check("rst out", mod_out, 48'd0);
    check("rst done", {47'd0, done}, 48'd0);
    check("rst busy", {47'd0, busy}, 48'd0);
    check("rst ovr", {47'd0, overrun}, 48'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    conv("unity", 1'b0, 8'd128, 12'd1024, pk(1024, -1024, 0, 2047), pk(512, -512, 0, 1023), 1'b0);
    conv("clamp", 1'b0, 8'd128, -12'sd2048, pk(1024, -2048, 2047, 0), pk(-1024, 2047, -2047, 0), 1'b0);
    conv("dsblc", 1'b1, 8'd128, 12'd1000, pk(-2048, 2047, 1024, 0), pk(0, 999, 750, 500), 1'b0);
    conv("gmax", 1'b0, 8'd255, 12'd2047, pk(2047, -2048, 64, -1), pk(2046, -2047, 126, -2), 1'b0);
    conv("ovrun", 1'b0, 8'd128, 12'd1024, pk(1024, -1024, 0, 2047), pk(512, -512, 0, 1023), 1'b1);
    conv("after", 1'b1, 8'd128, 12'd1000, pk(-2048, 2047, 1024, 0), pk(0, 999, 750, 500), 1'b0);

    // Abort a conversion with reset at C+2.
    @(negedge clk);
    mode = 1'b0; gain = 8'd128; carrier = 12'd1024; mod_in = pk(1024, 0, 0, 0); pls = 1'b1;
    repeat (2) @(posedge clk);
    #1 pls = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort out", mod_out, 48'd0);
    check("abort done", {47'd0, done}, 48'd0);
    check("abort busy", {47'd0, busy}, 48'd0);
    check("abort ovr", {47'd0, overrun}, 48'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("abort nodone", 48'(seen_done), 48'd0);
    prev_out = '0;
    conv("rerun", 1'b0, 8'd128, 12'd1024, pk(1024, -1024, 0, 2047), pk(512, -512, 0, 1023), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
